// File: rtl/calc_pkg.sv
// Shared definitions for the calculate-unit issue controller: mode codes, error codes,
// FSM state encoding and the slow-class decoder.
package calc_pkg;

    localparam logic [7:0] MODE_SUB    = 8'h00;
    localparam logic [7:0] MODE_ADD    = 8'h01;
    localparam logic [7:0] MODE_AND    = 8'h02;
    localparam logic [7:0] MODE_OR     = 8'h03;
    localparam logic [7:0] MODE_XOR    = 8'h04;
    localparam logic [7:0] MODE_SLL    = 8'h05;
    localparam logic [7:0] MODE_SRL    = 8'h06;
    localparam logic [7:0] MODE_SRA    = 8'h07;
    localparam logic [7:0] MODE_SLT    = 8'h08;
    localparam logic [7:0] MODE_SLTU   = 8'h09;
    localparam logic [7:0] MODE_BIT0   = 8'h30;
    localparam logic [7:0] MODE_MUL    = 8'h40;
    localparam logic [7:0] MODE_MULH   = 8'h41;
    localparam logic [7:0] MODE_MULHSU = 8'h42;
    localparam logic [7:0] MODE_MULHU  = 8'h43;
    localparam logic [7:0] MODE_DIV    = 8'h44;
    localparam logic [7:0] MODE_DIVU   = 8'h45;
    localparam logic [7:0] MODE_REM    = 8'h46;
    localparam logic [7:0] MODE_REMU   = 8'h47;

    localparam logic [3:0] NO_ERROR       = 4'd0;
    localparam logic [3:0] NO_INSTRUCTION = 4'd1;
    localparam logic [3:0] DIV_BY_ZERO    = 4'd2;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        SLOW,
        RESP
    } calc_state_e;

    // MUL/DIV class answers one clock late; every other code, known or not, is fast.
    function automatic logic is_slow(input logic [7:0] mode);
        return mode[7:4] == 4'h4;
    endfunction

endpackage

// File: rtl/calc_issue_stats.sv
// Three saturating event counters for the issue controller (accepted ops, slow ops, errored responses).
module calc_issue_stats
    import calc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_ops,
    input  logic             inc_slow,
    input  logic             inc_err,
    output logic [CNT_W-1:0] stat_ops,
    output logic [CNT_W-1:0] stat_slow,
    output logic [CNT_W-1:0] stat_err
);

    logic [CNT_W-1:0] ops_q, ops_d;
    logic [CNT_W-1:0] slow_q, slow_d;
    logic [CNT_W-1:0] err_q, err_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        ops_d  = ops_q;
        slow_d = slow_q;
        err_d  = err_q;
        if (inc_ops && (ops_q != '1))
            ops_d = ops_q + 1'b1;
        if (inc_slow && (slow_q != '1))
            slow_d = slow_q + 1'b1;
        if (inc_err && (err_q != '1))
            err_d = err_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_q  <= '0;
            slow_q <= '0;
            err_q  <= '0;
        end else begin
            ops_q  <= ops_d;
            slow_q <= slow_d;
            err_q  <= err_d;
        end
    end

    assign stat_ops  = ops_q;
    assign stat_slow = slow_q;
    assign stat_err  = err_q;

endmodule

// File: rtl/calc_issue_ctrl.sv
// Issue-side controller for the calculate unit: registers operands into the unit, waits for the
// fast or slow answer, returns tagged data+error. Statistics counters enabled by CALC_ISSUE_STATS_EN.
module calc_issue_ctrl
    import calc_pkg::*;
#(
    parameter int TAG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       req_mode,
    input  logic [31:0]      req_num1,
    input  logic [31:0]      req_num2,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic [31:0]      ccu_number1,
    output logic [31:0]      ccu_number2,
    output logic [7:0]       ccu_mode,
    input  logic [31:0]      ccu_fast,
    input  logic [31:0]      ccu_slow,
    input  logic [3:0]       ccu_error,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [3:0]       rsp_err,
    output logic [CNT_W-1:0] stat_ops,
    output logic [CNT_W-1:0] stat_slow,
    output logic [CNT_W-1:0] stat_err
);

    calc_state_e      state_q, state_d;
    logic [31:0]      num1_q, num1_d;
    logic [31:0]      num2_q, num2_d;
    logic [7:0]       mode_q, mode_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic [3:0]       rsp_err_q, rsp_err_d;
    logic             accept;
    logic             rsp_fire;

    // Flush blocks new work in the same cycle it kills the in-flight op.
    assign req_ready = !flush && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == RESP);
    assign rsp_fire  = rsp_valid && rsp_ready && !flush;

    always_comb begin
        state_d    = state_q;
        num1_d     = num1_q;
        num2_d     = num2_q;
        mode_d     = mode_q;
        tag_d      = tag_q;
        rsp_data_d = rsp_data_q;
        rsp_tag_d  = rsp_tag_q;
        rsp_err_d  = rsp_err_q;

        if (flush) begin
            state_d = IDLE;
        end else begin
            if (accept) begin
                num1_d = req_num1;
                num2_d = req_num2;
                mode_d = req_mode;
                tag_d  = req_tag;
            end
            unique case (state_q)
                IDLE: begin
                    if (accept)
                        state_d = EXEC;
                end
                EXEC: begin
                    if (is_slow(mode_q)) begin
                        state_d = SLOW;
                    end else begin
                        rsp_data_d = ccu_fast;
                        rsp_err_d  = ccu_error;
                        rsp_tag_d  = tag_q;
                        state_d    = RESP;
                    end
                end
                SLOW: begin
                    rsp_data_d = ccu_slow;
                    rsp_err_d  = ccu_error;
                    rsp_tag_d  = tag_q;
                    state_d    = RESP;
                end
                RESP: begin
                    if (rsp_ready)
                        state_d = accept ? EXEC : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            num1_q     <= '0;
            num2_q     <= '0;
            mode_q     <= '0;
            tag_q      <= '0;
            rsp_data_q <= '0;
            rsp_tag_q  <= '0;
            rsp_err_q  <= '0;
        end else begin
            state_q    <= state_d;
            num1_q     <= num1_d;
            num2_q     <= num2_d;
            mode_q     <= mode_d;
            tag_q      <= tag_d;
            rsp_data_q <= rsp_data_d;
            rsp_tag_q  <= rsp_tag_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign ccu_number1 = num1_q;
    assign ccu_number2 = num2_q;
    assign ccu_mode    = mode_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_tag     = rsp_tag_q;
    assign rsp_err     = rsp_err_q;

`ifdef CALC_ISSUE_STATS_EN
    calc_issue_stats #(
        .CNT_W(CNT_W)
    ) u_stats (
        .clk      (clk),
        .rst      (rst),
        .inc_ops  (accept),
        .inc_slow (accept && is_slow(req_mode)),
        .inc_err  (rsp_fire && (rsp_err_q != NO_ERROR)),
        .stat_ops (stat_ops),
        .stat_slow(stat_slow),
        .stat_err (stat_err)
    );
`else
    assign stat_ops  = '0;
    assign stat_slow = '0;
    assign stat_err  = '0;
`endif

endmodule
